// File: rtl/path_emitter_if.sv
// path_emitter_if: output stream carrying {loc, dir, first} over valid/ready.
`default_nettype none
interface path_emitter_if #(
  parameter int LOC_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [LOC_W-1:0] out_loc;
  logic [1:0]       out_dir;
  logic             out_first;

  modport master (output out_valid, output out_loc, output out_dir, output out_first,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_loc, input  out_dir, input  out_first,
                  output out_ready);
endinterface
`default_nettype wire

// File: rtl/path_emitter.sv
//------------------------------------------------------------------------------
// path_emitter: drains the solver's location stack, emitting {loc, dir} per step
// and flagging non-adjacent moves. Optional macro PATH_LEN_COUNT_EN adds path_len.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
module path_emitter #(
  parameter int COORD_W = 4,
  parameter int LOC_W   = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic             emp_stck,
  input  wire logic [LOC_W-1:0] loc_in,
  output logic                  pop,
  output logic                  adj_err,
  output logic                  finished,
  path_emitter_if.master        out_if
`ifdef PATH_LEN_COUNT_EN
  ,
  output logic [7:0]            path_len
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_POP  = 3'd1;
  localparam logic [2:0] S_CAPT = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [COORD_W:0] c_one = {{COORD_W{1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [LOC_W-1:0] r_prev;
  logic             r_first;
  logic [LOC_W-1:0] r_loc;
  logic [1:0]       r_dir;
  logic             r_valid;
  logic             r_out_first;
  logic             r_adj_err;
  logic             r_finished;

  logic [COORD_W:0] w_xn, w_yn, w_xp, w_yp;
  logic             w_xeq, w_yeq;
  logic [1:0]       w_dir;
  logic             w_adj_ok;
  logic             w_restart;
  logic             w_hs;

  // Coordinates extended by one bit so +1 cannot wrap at the grid edge.
  assign w_xn  = {1'b0, loc_in[LOC_W-1:COORD_W]};
  assign w_yn  = {1'b0, loc_in[COORD_W-1:0]};
  assign w_xp  = {1'b0, r_prev[LOC_W-1:COORD_W]};
  assign w_yp  = {1'b0, r_prev[COORD_W-1:0]};
  assign w_xeq = (w_xn == w_xp);
  assign w_yeq = (w_yn == w_yp);

  always_comb begin
    w_dir    = 2'b00;
    w_adj_ok = 1'b0;
    if (w_yeq && (w_xn == w_xp + c_one)) begin
      w_dir    = 2'b00;
      w_adj_ok = 1'b1;
    end else if (w_yeq && (w_xn + c_one == w_xp)) begin
      w_dir    = 2'b01;
      w_adj_ok = 1'b1;
    end else if (w_xeq && (w_yn == w_yp + c_one)) begin
      w_dir    = 2'b10;
      w_adj_ok = 1'b1;
    end else if (w_xeq && (w_yn + c_one == w_yp)) begin
      w_dir    = 2'b11;
      w_adj_ok = 1'b1;
    end
  end

  assign w_restart = start && ((r_state == S_IDLE) || (r_state == S_FIN));
  assign w_hs      = (r_state == S_EMIT) && out_if.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_first     <= 1'b1;
      r_loc       <= '0;
      r_dir       <= 2'b00;
      r_valid     <= 1'b0;
      r_out_first <= 1'b0;
      r_adj_err   <= 1'b0;
      r_finished  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (w_restart) begin
            r_adj_err  <= 1'b0;
            r_finished <= 1'b0;
            r_first    <= 1'b1;
            r_state    <= S_POP;
          end
        end
        S_POP: begin
          if (emp_stck) begin
            r_finished <= 1'b1;
            r_state    <= S_FIN;
          end else begin
            r_state    <= S_CAPT;
          end
        end
        S_CAPT: begin
          r_loc   <= loc_in;
          r_valid <= 1'b1;
          if (r_first) begin
            r_dir       <= 2'b00;
            r_out_first <= 1'b1;
          end else begin
            r_dir <= w_adj_ok ? w_dir : 2'b00;
            if (!w_adj_ok) r_adj_err <= 1'b1;
          end
          r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (w_hs) begin
            r_valid     <= 1'b0;
            r_out_first <= 1'b0;
            r_prev      <= r_loc;
            r_first     <= 1'b0;
            r_state     <= S_POP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The stack samples pop at the edge that leaves POP; an empty stack is never popped.
  assign pop              = (r_state == S_POP) && !emp_stck;
  assign adj_err          = r_adj_err;
  assign finished         = r_finished;
  assign out_if.out_valid = r_valid;
  assign out_if.out_loc   = r_loc;
  assign out_if.out_dir   = r_dir;
  assign out_if.out_first = r_out_first;

`ifdef PATH_LEN_COUNT_EN
  logic [7:0] r_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len <= 8'd0;
    end else if (w_restart) begin
      r_len <= 8'd0;
    end else if (w_hs && (r_len != 8'hFF)) begin
      r_len <= r_len + 8'd1;
    end
  end

  assign path_len = r_len;
`endif

endmodule
`default_nettype wire

// File: tb/tb_path_emitter.sv
// tb_path_emitter: directed vectors against path_emitter with a small stack model.
`default_nettype none
module tb_path_emitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       emp_stck;
  logic [7:0] loc_in;
  logic       pop;
  logic       adj_err;
  logic       finished;
`ifdef PATH_LEN_COUNT_EN
  logic [7:0] path_len;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  path_emitter_if #(.LOC_W(8)) pif ();

  path_emitter #(.COORD_W(4), .LOC_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .emp_stck (emp_stck),
    .loc_in   (loc_in),
    .pop      (pop),
    .adj_err  (adj_err),
    .finished (finished),
    .out_if   (pif)
`ifdef PATH_LEN_COUNT_EN
    ,
    .path_len (path_len)
`endif
  );

  // Stack model: pop sampled at a rising edge, data valid the following cycle.
  logic [7:0] mem [0:15];
  int         cnt;
  logic [4:0] ptr;
  logic       stk_load;

  assign emp_stck = (int'(ptr) >= cnt);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= 5'd0;
      loc_in <= 8'h00;
    end else if (stk_load) begin
      ptr <= 5'd0;
    end else if (pop) begin
      loc_in <= mem[ptr[3:0]];
      ptr    <= ptr + 5'd1;
    end
  end

  logic bad_pop = 1'b0;
  logic pop_d   = 1'b0;

  always @(posedge clk) begin
    pop_d <= pop & rst;
    if (rst && pop && (emp_stck || pop_d)) bad_pop <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load(input int n, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] a2, input logic [7:0] a3);
    mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = a3;
    cnt      = n;
    stk_load = 1'b1;
    cyc();
    stk_load = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic expect_item(input string tag, input logic [7:0] l, input logic [1:0] d,
                             input logic f, input int hold);
    int w = 0;
    pif.out_ready = (hold == 0);
    while (!pif.out_valid && w < 20) begin
      cyc();
      w++;
    end
    chk({tag, ".valid"}, 32'(pif.out_valid), 32'd1);
    chk({tag, ".gap"},   32'(w),             32'd2);
    chk({tag, ".loc"},   32'(pif.out_loc),   32'(l));
    chk({tag, ".dir"},   32'(pif.out_dir),   32'(d));
    chk({tag, ".first"}, 32'(pif.out_first), 32'(f));
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk({tag, ".hold"}, 32'({pif.out_valid, pif.out_loc, pif.out_dir, pif.out_first, pop}),
          32'({1'b1, l, d, f, 1'b0}));
    end
    pif.out_ready = 1'b1;
    cyc();
  endtask

  task automatic wait_fin(input string tag);
    int w = 0;
    while (!finished && w < 10) begin
      cyc();
      w++;
    end
    chk({tag, ".fin"},     32'(finished), 32'd1);
    chk({tag, ".fin_lat"}, 32'(w),        32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    start         = 1'b0;
    stk_load      = 1'b0;
    cnt           = 0;
    pif.out_ready = 1'b0;

    // Reset held with start toggling
    for (int i = 0; i < 4; i++) begin
      start = i[0];
      cyc();
      chk("rst.outs", 32'({pop, pif.out_valid, finished, adj_err, pif.out_first, pif.out_loc}),
          32'd0);
    end
    start = 1'b0;
    rst   = 1'b1;
    cyc();

    // Straight path
    load(4, 8'h00, 8'h10, 8'h20, 8'h21);
    kick();
    expect_item("st0", 8'h00, 2'b00, 1'b1, 0);
    expect_item("st1", 8'h10, 2'b00, 1'b0, 0);
    expect_item("st2", 8'h20, 2'b00, 1'b0, 0);
    expect_item("st3", 8'h21, 2'b10, 1'b0, 0);
    wait_fin("st");
    chk("st.adj", 32'(adj_err), 32'd0);
`ifdef PATH_LEN_COUNT_EN
    chk("st.len", 32'(path_len), 32'd4);
`endif

    // Backpressure on the second item
    load(4, 8'h00, 8'h10, 8'h20, 8'h21);
    kick();
    chk("bp.fin_clr", 32'(finished), 32'd0);
    expect_item("bp0", 8'h00, 2'b00, 1'b1, 0);
    expect_item("bp1", 8'h10, 2'b00, 1'b0, 5);
    expect_item("bp2", 8'h20, 2'b00, 1'b0, 0);
    expect_item("bp3", 8'h21, 2'b10, 1'b0, 0);
    wait_fin("bp");

    // Reverse moves
    load(3, 8'h22, 8'h12, 8'h11, 8'h00);
    kick();
    expect_item("rv0", 8'h22, 2'b00, 1'b1, 0);
    expect_item("rv1", 8'h12, 2'b01, 1'b0, 0);
    expect_item("rv2", 8'h11, 2'b11, 1'b0, 0);
    wait_fin("rv");
    chk("rv.adj", 32'(adj_err), 32'd0);

    // Non-adjacent jump
    load(2, 8'h00, 8'h22, 8'h00, 8'h00);
    kick();
    expect_item("na0", 8'h00, 2'b00, 1'b1, 0);
    chk("na0.adj", 32'(adj_err), 32'd0);
    expect_item("na1", 8'h22, 2'b00, 1'b0, 0);
    chk("na1.adj", 32'(adj_err), 32'd1);
    wait_fin("na");
    chk("na.adj_sticky", 32'(adj_err), 32'd1);

    // Empty stack: start clears adj_err, no pop, finished two cycles after start
    load(0, 8'h00, 8'h00, 8'h00, 8'h00);
    kick();
    chk("emp.pop",   32'(pop),      32'd0);
    chk("emp.adj",   32'(adj_err),  32'd0);
    chk("emp.fin0",  32'(finished), 32'd0);
    cyc();
    chk("emp.fin1",  32'(finished), 32'd1);
`ifdef PATH_LEN_COUNT_EN
    chk("emp.len", 32'(path_len), 32'd0);
`endif

    // Reset while in EMIT, then a clean restart
    load(2, 8'h00, 8'h10, 8'h00, 8'h00);
    kick();
    pif.out_ready = 1'b0;
    for (int w = 0; w < 20 && !pif.out_valid; w++) cyc();
    chk("mr.valid_pre", 32'(pif.out_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("mr.valid_rst", 32'(pif.out_valid), 32'd0);
    chk("mr.outs_rst", 32'({pop, finished, pif.out_first, pif.out_loc, pif.out_dir}), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    load(2, 8'h00, 8'h10, 8'h00, 8'h00);
    kick();
    expect_item("mr0", 8'h00, 2'b00, 1'b1, 0);
    expect_item("mr1", 8'h10, 2'b00, 1'b0, 0);
    wait_fin("mr");

    chk("pop_rule", 32'(bad_pop), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
